elbeth_decode_stage: RTL and testbench
======================================

// Module: elbeth_decode_stage
// PURPOSE
//  Registered instruction-decode stage. It sits between fetch and execute and replaces the
//  purely combinational decoder. Each accepted instruction is decoded once, on entry. The result
//  is held in a DEPTH-entry in-order queue, with valid/ready handshakes on both sides and a flush.
//  Additions over the combinational decoder: illegal-instruction flag, control flags, optional
//  MUL decode, XLEN-wide immediates, and all-zero defaults (no latched fields).
// PARAMETERS
//  XLEN        32  datapath width; imm/offset/pc sign-extended to XLEN; legal values 32, 64
//  DEPTH       2   decoded-entry queue depth; legal range 1..8
//  ENABLE_MUL  0   1: decode R-type funct7=7'h01, funct3 0..3 as OP_MUL/MULH/MULHSU/MULHU
// PORTS
//  clk               in   1     clock, rising edge
//  rst               in   1     asynchronous, active-high reset
//  flush             in   1     discard every queued entry and the current input word
//  in_valid          in   1     fetch offers in_inst/in_pc
//  in_ready          out  1     stage accepts this cycle
//  in_inst           in   32    raw instruction
//  in_pc             in   XLEN  pc of in_inst
//  out_valid         out  1     head entry valid
//  out_ready         in   1     execute consumes head
//  out_pc            out  XLEN  pc of head
//  out_rd_addr       out  5     destination register
//  out_rs1_addr      out  5     source register 1
//  out_rs2_addr      out  5     source register 2
//  out_imm           out  XLEN  ALU immediate/shamt; 4 for JAL/JALR; U-imm<<12 for LUI/AUIPC
//  out_offset_branch out  XLEN  branch/jump offset
//  out_op_alu        out  4     ALU op code, `OP_* encoding
//  out_op_branch     out  4     branch op code, `OP_* encoding; `OP_BR_NONE if not a branch
//  out_rd_we         out  1     writes rd (0 if rd==0 or illegal)
//  out_mem_rd        out  1     load
//  out_mem_wr        out  1     store
//  out_illegal       out  1     undecodable instruction
// BEHAVIOUR
//  - Reset (async, immediate): count=0, rd/wr ptr=0, out_valid=0, all out_* fields 0; in_ready=1 once rst drops.
//  - Push condition: in_valid && in_ready && !flush. Pop condition: out_valid && out_ready && !flush.
//  - in_ready = (count<DEPTH) || out_ready. When full, a pop and a push in the same cycle are both
//    allowed (pass-through at full).
//  - Latency: a word pushed at edge N is at the head after edge N, if the queue was empty. There is
//    no combinational in->out path.
//  - Occupancy states: EMPTY (count 0), PARTIAL, FULL (count DEPTH).
//      EMPTY->PARTIAL on push. PARTIAL->FULL on push without pop. Any state->EMPTY on flush.
//      FULL->PARTIAL on pop without push. PARTIAL->EMPTY on pop without push when count==1.
//      DEPTH==1: push moves EMPTY directly to FULL; pop without push moves FULL directly to EMPTY.
//  - Pointers: binary, wrap from DEPTH-1 to 0. count is $clog2(DEPTH+1) bits.
//  - flush has priority over push and pop: the queue empties at the edge, and the input word is
//    dropped even when in_valid=1.
//  - out_valid = (count!=0). The out_* fields are taken from the head entry. When out_valid=0 they
//    are held at 0.
//  - Decode defaults: every field 0, op_branch=`OP_BR_NONE.
//      Immediates: I/S/B/U/J formats, sign-extended to XLEN.
//      Shift shamt: zero-extended 5 bits.
//  - Illegal cases:
//      unknown opcode;
//      SB funct3 2 or 3;
//      R-type funct7 not 0x00/0x20 (0x01 is legal only when ENABLE_MUL and funct3<=3);
//      0x20 allowed only with funct3 0 or 5;
//      SLLI with funct7!=0; SRLI/SRAI with funct7 not 0x00/0x20.
//    Illegal => out_illegal=1, rd_we=mem_rd=mem_wr=0, op_branch=`OP_BR_NONE, op_alu=`OP_ADD.
// STRUCTURE
//  - elbeth_definitions.v gains `OP_BR_NONE, `OP_MUL, `OP_MULH, `OP_MULHSU, `OP_MULHU.
//    The existing `OP_TYPE_* and `OP_* constants are reused unchanged.
//  - Sub-module elbeth_decode_core: purely combinational. Input inst; outputs all decoded fields.
//    It is instantiated once on the input side.
//  - Top level: entry storage as a register array of {pc, decoded fields}, plus pointer/count
//    logic and handshake logic.
// TESTING
//  - ADDI x1,x0,-1 (0xFFF00093), pc=0x100, out_ready=1
//      -> next cycle: out_valid=1, rd=1, rs1=0, imm=0xFFFFFFFF, op_alu=`OP_ADD, rd_we=1, pc=0x100.
//  - BEQ x1,x2,-8 (0xFE208CE3)
//      -> rs1=1, rs2=2, offset_branch=0xFFFFFFF8, op_branch=`OP_BEQ, rd_we=0.
//  - DEPTH=2, out_ready=0, push words A,B,C
//      -> in_ready=0 after B. Then out_ready=1 -> A,B,C drain in order, one per cycle, no loss.
//  - Queue holds 1 entry; flush=1 with in_valid=1
//      -> next cycle out_valid=0, count 0, word not enqueued.
//  - 0x0000000B (custom-0) -> out_illegal=1, rd_we=0.
//    MUL x0,x1,x2 (0x02208033): ENABLE_MUL=0 -> illegal; ENABLE_MUL=1 -> op_alu=`OP_MUL, rd_we=0.
//  - rst asserted mid-stream with 2 entries queued
//      -> out_valid=0 immediately. After release: in_ready=1, and no stale entry is ever emitted.

Source files
------------

// File: rtl/elbeth_decode_pkg.sv
// Elbeth decode stage: op encodings, opcodes,
// decoded control bundle and occupancy states.
package elbeth_decode_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_SLL    = 4'd2;
  localparam logic [3:0] OP_SLT    = 4'd3;
  localparam logic [3:0] OP_SLTU   = 4'd4;
  localparam logic [3:0] OP_XOR    = 4'd5;
  localparam logic [3:0] OP_SRL    = 4'd6;
  localparam logic [3:0] OP_SRA    = 4'd7;
  localparam logic [3:0] OP_OR     = 4'd8;
  localparam logic [3:0] OP_AND    = 4'd9;
  localparam logic [3:0] OP_MUL    = 4'd10;
  localparam logic [3:0] OP_MULH   = 4'd11;
  localparam logic [3:0] OP_MULHSU = 4'd12;
  localparam logic [3:0] OP_MULHU  = 4'd13;

  localparam logic [3:0] OP_BR_NONE = 4'd0;
  localparam logic [3:0] OP_BEQ     = 4'd1;
  localparam logic [3:0] OP_BNE     = 4'd2;
  localparam logic [3:0] OP_BLT     = 4'd3;
  localparam logic [3:0] OP_BGE     = 4'd4;
  localparam logic [3:0] OP_BLTU    = 4'd5;
  localparam logic [3:0] OP_BGEU    = 4'd6;
  localparam logic [3:0] OP_JAL     = 4'd7;
  localparam logic [3:0] OP_JALR    = 4'd8;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  localparam logic [6:0] F7_MUL  = 7'h01;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] op_alu;
    logic [3:0] op_branch;
    logic       rd_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
  } dec_ctl_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_e;

  function automatic logic [3:0] reg_alu_op(
    input logic [2:0] f3
  );
    unique case (f3)
      3'd0: return OP_ADD;
      3'd1: return OP_SLL;
      3'd2: return OP_SLT;
      3'd3: return OP_SLTU;
      3'd4: return OP_XOR;
      3'd5: return OP_SRL;
      3'd6: return OP_OR;
      default: return OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/elbeth_decode_if.sv
// Fetch-side and execute-side handshakes of
// the decode stage, bundled in one interface.
interface elbeth_decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd_addr;
  logic [4:0]      out_rs1_addr;
  logic [4:0]      out_rs2_addr;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_offset_branch;
  logic [3:0]      out_op_alu;
  logic [3:0]      out_op_branch;
  logic            out_rd_we;
  logic            out_mem_rd;
  logic            out_mem_wr;
  logic            out_illegal;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc,
    input  out_rd_addr, out_rs1_addr, out_rs2_addr,
    input  out_imm, out_offset_branch,
    input  out_op_alu, out_op_branch,
    input  out_rd_we, out_mem_rd, out_mem_wr,
    input  out_illegal
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc,
    output out_rd_addr, out_rs1_addr, out_rs2_addr,
    output out_imm, out_offset_branch,
    output out_op_alu, out_op_branch,
    output out_rd_we, out_mem_rd, out_mem_wr,
    output out_illegal
  );
endinterface

// File: rtl/elbeth_decode_core.sv
// Combinational RV32I(+M) decoder producing
// control fields and XLEN-wide immediates.
module elbeth_decode_core
  import elbeth_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ENABLE_MUL = 0
) (
  input  logic [31:0]     inst_i,
  output dec_ctl_t        ctl_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] off_o
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opc = inst_i[6:0];
  assign rd  = inst_i[11:7];
  assign f3  = inst_i[14:12];
  assign rs1 = inst_i[19:15];
  assign rs2 = inst_i[24:20];
  assign f7  = inst_i[31:25];

  logic signed [31:0] imm_i;
  logic signed [31:0] imm_s;
  logic signed [31:0] imm_b;
  logic signed [31:0] imm_u;
  logic signed [31:0] imm_j;
  logic signed [31:0] shamt;

  assign imm_i = {{20{inst_i[31]}}, inst_i[31:20]};
  assign imm_s = {{20{inst_i[31]}}, f7, rd};
  assign imm_b = {{20{inst_i[31]}}, inst_i[7],
                  inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_u = {inst_i[31:12], 12'h000};
  assign imm_j = {{12{inst_i[31]}}, inst_i[19:12],
                  inst_i[20], inst_i[30:21], 1'b0};
  assign shamt = {27'd0, inst_i[24:20]};

  dec_ctl_t           c;
  logic signed [31:0] imm;
  logic signed [31:0] off;
  logic               wr;
  logic               bad;

  always_comb begin
    c   = '0;
    imm = '0;
    off = '0;
    wr  = 1'b0;
    bad = 1'b0;
    unique case (1'b1)
      opc == OPC_LUI,
      opc == OPC_AUIPC: begin
        c.rd = rd;
        imm  = imm_u;
        wr   = 1'b1;
      end
      opc == OPC_JAL: begin
        c.rd        = rd;
        imm         = 32'sd4;
        off         = imm_j;
        c.op_branch = OP_JAL;
        wr          = 1'b1;
      end
      opc == OPC_JALR: begin
        c.rd        = rd;
        c.rs1       = rs1;
        imm         = 32'sd4;
        off         = imm_i;
        c.op_branch = OP_JALR;
        wr          = 1'b1;
      end
      opc == OPC_BRANCH: begin
        c.rs1 = rs1;
        c.rs2 = rs2;
        off   = imm_b;
        unique case (f3)
          3'd0: c.op_branch = OP_BEQ;
          3'd1: c.op_branch = OP_BNE;
          3'd4: c.op_branch = OP_BLT;
          3'd5: c.op_branch = OP_BGE;
          3'd6: c.op_branch = OP_BLTU;
          3'd7: c.op_branch = OP_BGEU;
          default: bad = 1'b1;
        endcase
      end
      opc == OPC_LOAD: begin
        c.rd     = rd;
        c.rs1    = rs1;
        imm      = imm_i;
        c.mem_rd = 1'b1;
        wr       = 1'b1;
      end
      opc == OPC_STORE: begin
        c.rs1    = rs1;
        c.rs2    = rs2;
        imm      = imm_s;
        c.mem_wr = 1'b1;
      end
      opc == OPC_OPIMM: begin
        c.rd     = rd;
        c.rs1    = rs1;
        wr       = 1'b1;
        imm      = imm_i;
        c.op_alu = reg_alu_op(f3);
        if (f3 == 3'd1) begin
          imm = shamt;
          bad = (f7 != F7_BASE);
        end else if (f3 == 3'd5) begin
          imm = shamt;
          if (f7 == F7_ALT) c.op_alu = OP_SRA;
          else bad = (f7 != F7_BASE);
        end
      end
      opc == OPC_OP: begin
        c.rd  = rd;
        c.rs1 = rs1;
        c.rs2 = rs2;
        wr    = 1'b1;
        unique case (1'b1)
          f7 == F7_BASE:
            c.op_alu = reg_alu_op(f3);
          f7 == F7_ALT && f3 == 3'd0:
            c.op_alu = OP_SUB;
          f7 == F7_ALT && f3 == 3'd5:
            c.op_alu = OP_SRA;
          f7 == F7_MUL && ENABLE_MUL != 0 && !f3[2]:
            c.op_alu = OP_MUL + {2'b00, f3[1:0]};
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // An illegal word carries nothing downstream but the flag
    if (bad) begin
      c         = '0;
      c.illegal = 1'b1;
      imm       = '0;
      off       = '0;
      wr        = 1'b0;
    end
    c.rd_we = wr && (c.rd != 5'd0);
  end

  assign ctl_o = c;
  assign imm_o = XLEN'(imm);
  assign off_o = XLEN'(off);

endmodule

// File: rtl/elbeth_decode_stage.sv
// Registered decode stage: decode on entry,
// in-order DEPTH-entry queue towards execute.
module elbeth_decode_stage
  import elbeth_decode_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 2,
  parameter int ENABLE_MUL = 0
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  elbeth_decode_if.slave   dec_if
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  dec_ctl_t        ctl_in;
  logic [XLEN-1:0] imm_in;
  logic [XLEN-1:0] off_in;

  elbeth_decode_core #(
    .XLEN       (XLEN),
    .ENABLE_MUL (ENABLE_MUL)
  ) u_core (
    .inst_i (dec_if.in_inst),
    .ctl_o  (ctl_in),
    .imm_o  (imm_in),
    .off_o  (off_in)
  );

  dec_ctl_t        ctl_q [DEPTH];
  logic [XLEN-1:0] pc_q  [DEPTH];
  logic [XLEN-1:0] imm_q [DEPTH];
  logic [XLEN-1:0] off_q [DEPTH];

  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  occ_e          occ_q;

  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign dec_if.out_valid = (occ_q != OCC_EMPTY);
  assign dec_if.in_ready  = (occ_q != OCC_FULL) ||
                            dec_if.out_ready;

  assign push = dec_if.in_valid && dec_if.in_ready &&
                !flush;
  assign pop  = dec_if.out_valid && dec_if.out_ready &&
                !flush;

  // Payload needs no reset: it is only visible via out_valid
  always_ff @(posedge clk) begin
    if (push) begin
      ctl_q[wr_ptr_q] <= ctl_in;
      pc_q[wr_ptr_q]  <= dec_if.in_pc;
      imm_q[wr_ptr_q] <= imm_in;
      off_q[wr_ptr_q] <= off_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= OCC_EMPTY;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      occ_q    <= OCC_EMPTY;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      unique case (occ_q)
        OCC_EMPTY:
          if (push)
            occ_q <= (DEPTH == 1) ? OCC_FULL
                                  : OCC_PARTIAL;
        OCC_PARTIAL:
          if (push && !pop &&
              cnt_q == CW'(DEPTH - 1))
            occ_q <= OCC_FULL;
          else if (pop && !push &&
                   cnt_q == CW'(1))
            occ_q <= OCC_EMPTY;
        OCC_FULL:
          if (pop && !push)
            occ_q <= (DEPTH == 1) ? OCC_EMPTY
                                  : OCC_PARTIAL;
        default: occ_q <= OCC_EMPTY;
      endcase
    end
  end

  dec_ctl_t head;

  always_comb begin
    head                     = '0;
    dec_if.out_pc            = '0;
    dec_if.out_imm           = '0;
    dec_if.out_offset_branch = '0;
    if (dec_if.out_valid) begin
      head                     = ctl_q[rd_ptr_q];
      dec_if.out_pc            = pc_q[rd_ptr_q];
      dec_if.out_imm           = imm_q[rd_ptr_q];
      dec_if.out_offset_branch = off_q[rd_ptr_q];
    end
  end

  assign dec_if.out_rd_addr   = head.rd;
  assign dec_if.out_rs1_addr  = head.rs1;
  assign dec_if.out_rs2_addr  = head.rs2;
  assign dec_if.out_op_alu    = head.op_alu;
  assign dec_if.out_op_branch = head.op_branch;
  assign dec_if.out_rd_we     = head.rd_we;
  assign dec_if.out_mem_rd    = head.mem_rd;
  assign dec_if.out_mem_wr    = head.mem_wr;
  assign dec_if.out_illegal   = head.illegal;

endmodule

// File: tb/tb_elbeth_decode_stage.sv
// Scoreboard bench: two stages (MUL off/on) fed
// the same stream, checked against a field model.
module tb_elbeth_decode_stage;
  import elbeth_decode_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] off;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [3:0]  alu;
    logic [3:0]  br;
    logic        we;
    logic        mr;
    logic        mw;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;

  int errors = 0;
  int checks = 0;

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  elbeth_decode_if #(.XLEN(XLEN)) if0 ();
  elbeth_decode_if #(.XLEN(XLEN)) if1 ();

  assign if0.in_valid  = in_valid;
  assign if0.in_inst   = in_inst;
  assign if0.in_pc     = in_pc;
  assign if0.out_ready = out_ready;
  assign if1.in_valid  = in_valid;
  assign if1.in_inst   = in_inst;
  assign if1.in_pc     = in_pc;
  assign if1.out_ready = out_ready;

  elbeth_decode_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_MUL(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .dec_if(if0)
  );

  elbeth_decode_stage #(
    .XLEN(XLEN), .DEPTH(DEPTH), .ENABLE_MUL(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .dec_if(if1)
  );

  exp_t a0;
  exp_t a1;

  assign a0 = {if0.out_pc, if0.out_imm,
               if0.out_offset_branch, if0.out_rd_addr,
               if0.out_rs1_addr, if0.out_rs2_addr,
               if0.out_op_alu, if0.out_op_branch,
               if0.out_rd_we, if0.out_mem_rd,
               if0.out_mem_wr, if0.out_illegal};
  assign a1 = {if1.out_pc, if1.out_imm,
               if1.out_offset_branch, if1.out_rd_addr,
               if1.out_rs1_addr, if1.out_rs2_addr,
               if1.out_op_alu, if1.out_op_branch,
               if1.out_rd_we, if1.out_mem_rd,
               if1.out_mem_wr, if1.out_illegal};

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  task automatic cmp(input string t, input exp_t a,
                     input exp_t x);
    chk({t, ".pc"},  a.pc,  x.pc);
    chk({t, ".imm"}, a.imm, x.imm);
    chk({t, ".off"}, a.off, x.off);
    chk({t, ".rd"},  32'(a.rd),  32'(x.rd));
    chk({t, ".rs1"}, 32'(a.rs1), 32'(x.rs1));
    chk({t, ".rs2"}, 32'(a.rs2), 32'(x.rs2));
    chk({t, ".alu"}, 32'(a.alu), 32'(x.alu));
    chk({t, ".br"},  32'(a.br),  32'(x.br));
    chk({t, ".flags"},
        32'({a.we, a.mr, a.mw, a.ill}),
        32'({x.we, x.mr, x.mw, x.ill}));
  endtask

  // Reference decode from instruction-set rules
  function automatic exp_t ref_decode(
    input logic [31:0] i, input bit mul);
    exp_t e;
    logic [3:0] regop [8];
    logic [3:0] brop [8];
    int op, f3, f7, neg, negj;
    bit bad, wr;
    regop = '{OP_ADD, OP_SLL, OP_SLT, OP_SLTU,
              OP_XOR, OP_SRL, OP_OR, OP_AND};
    brop  = '{OP_BEQ, OP_BNE, OP_BR_NONE, OP_BR_NONE,
              OP_BLT, OP_BGE, OP_BLTU, OP_BGEU};
    e    = '0;
    bad  = 1'b0;
    wr   = 1'b0;
    op   = i & 32'h7f;
    f3   = (i >> 12) & 7;
    f7   = (i >> 25) & 127;
    neg  = i[31] ? 4096 : 0;
    negj = i[31] ? 32'h100000 : 0;
    case (op)
      'h37, 'h17: begin
        e.rd = i[11:7]; wr = 1;
        e.imm = i & 32'hfffff000;
      end
      'h6f: begin
        e.rd = i[11:7]; wr = 1; e.imm = 4;
        e.br = OP_JAL;
        e.off = ((i >> 12) & 255) * 4096 +
                ((i >> 20) & 1) * 2048 +
                ((i >> 21) & 1023) * 2 - negj;
      end
      'h67: begin
        e.rd = i[11:7]; e.rs1 = i[19:15]; wr = 1;
        e.imm = 4; e.br = OP_JALR;
        e.off = (i >> 20) - neg;
      end
      'h63: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20];
        e.off = ((i >> 7) & 1) * 2048 +
                ((i >> 25) & 63) * 32 +
                ((i >> 8) & 15) * 2 - neg;
        if (f3 == 2 || f3 == 3) bad = 1;
        else e.br = brop[f3];
      end
      'h03: begin
        e.rd = i[11:7]; e.rs1 = i[19:15]; wr = 1;
        e.mr = 1; e.imm = (i >> 20) - neg;
      end
      'h23: begin
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.mw = 1;
        e.imm = f7 * 32 + ((i >> 7) & 31) - neg;
      end
      'h13: begin
        e.rd = i[11:7]; e.rs1 = i[19:15]; wr = 1;
        e.alu = regop[f3];
        e.imm = (i >> 20) - neg;
        if (f3 == 1 || f3 == 5) e.imm = (i >> 20) & 31;
        if (f3 == 1 && f7 != 0) bad = 1;
        if (f3 == 5 && f7 == 'h20) e.alu = OP_SRA;
        else if (f3 == 5 && f7 != 0) bad = 1;
      end
      'h33: begin
        e.rd = i[11:7]; e.rs1 = i[19:15];
        e.rs2 = i[24:20]; wr = 1;
        if (f7 == 0) e.alu = regop[f3];
        else if (f7 == 'h20 && f3 == 0) e.alu = OP_SUB;
        else if (f7 == 'h20 && f3 == 5) e.alu = OP_SRA;
        else if (f7 == 1 && mul && f3 < 4)
          e.alu = (f3 == 0) ? OP_MUL :
                  (f3 == 1) ? OP_MULH :
                  (f3 == 2) ? OP_MULHSU : OP_MULHU;
        else bad = 1;
      end
      default: bad = 1;
    endcase
    if (bad) begin
      e = '0;
      e.ill = 1'b1;
    end else begin
      e.we = wr && (e.rd != 0);
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [6:0]  opcs [10];
    logic [31:0] w;
    opcs = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63,
             7'h03, 7'h23, 7'h13, 7'h33, 7'h0b};
    w = $urandom;
    if ($urandom_range(0, 9) != 0)
      w[6:0] = opcs[$urandom_range(0, 9)];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      default: ;
    endcase
    return w;
  endfunction

  // Monitor: compares the head against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("in_ready0", 32'(if0.in_ready),
            32'((q0.size() < DEPTH) || out_ready));
        chk("in_ready1", 32'(if1.in_ready),
            32'((q1.size() < DEPTH) || out_ready));
        chk("out_valid0", 32'(if0.out_valid),
            32'(q0.size() != 0));
        chk("out_valid1", 32'(if1.out_valid),
            32'(q1.size() != 0));
        if (q0.size() != 0) begin
          cmp("head0", a0, q0[0]);
          cmp("head1", a1, q1[0]);
          if (out_ready && !flush) begin
            void'(q0.pop_front());
            void'(q1.pop_front());
          end
        end else begin
          cmp("idle0", a0, '0);
          cmp("idle1", a1, '0);
        end
      end
    end
  end

  task automatic step();
    exp_t e0;
    exp_t e1;
    @(posedge clk);
    if (!rst) begin
      if (flush) begin
        q0.delete();
        q1.delete();
      end else if (in_valid &&
                   ((q0.size() < DEPTH) || out_ready)) begin
        e0 = ref_decode(in_inst, 1'b0);
        e1 = ref_decode(in_inst, 1'b1);
        e0.pc = in_pc;
        e1.pc = in_pc;
        q0.push_back(e0);
        q1.push_back(e1);
      end
    end
    #1;
  endtask

  task automatic drive(input bit v,
                       input logic [31:0] ins,
                       input logic [31:0] pc,
                       input bit ordy, input bit fl);
    in_valid  = v;
    in_inst   = ins;
    in_pc     = pc;
    out_ready = ordy;
    flush     = fl;
    step();
  endtask

  initial begin
    logic [31:0] pc;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 32'(if0.out_valid), 0);
    cmp("rst.fields", a0, '0);
    rst = 1'b0;
    #1;
    chk("rst.in_ready", 32'(if0.in_ready), 1);

    drive(1, 32'hfff00093, 32'h100, 1, 0);
    chk("addi.valid", 32'(if0.out_valid), 1);
    chk("addi.rd", 32'(if0.out_rd_addr), 1);
    chk("addi.rs1", 32'(if0.out_rs1_addr), 0);
    chk("addi.imm", if0.out_imm, 32'hffffffff);
    chk("addi.alu", 32'(if0.out_op_alu), 32'(OP_ADD));
    chk("addi.we", 32'(if0.out_rd_we), 1);
    chk("addi.pc", if0.out_pc, 32'h100);

    drive(1, 32'hfe208ce3, 32'h104, 1, 0);
    chk("beq.rs1", 32'(if0.out_rs1_addr), 1);
    chk("beq.rs2", 32'(if0.out_rs2_addr), 2);
    chk("beq.off", if0.out_offset_branch,
        32'hfffffff8);
    chk("beq.br", 32'(if0.out_op_branch),
        32'(OP_BEQ));
    chk("beq.we", 32'(if0.out_rd_we), 0);

    drive(0, 0, 0, 1, 0);
    drive(1, 32'h00a00513, 32'h200, 0, 0);
    drive(1, 32'h00b00593, 32'h204, 0, 0);
    chk("full.in_ready", 32'(if0.in_ready), 0);
    drive(1, 32'h00c00613, 32'h208, 0, 0);
    drive(1, 32'h00c00613, 32'h208, 1, 0);
    repeat (3) drive(0, 0, 0, 1, 0);

    drive(1, 32'h00100093, 32'h300, 0, 0);
    drive(1, 32'h00200113, 32'h304, 0, 1);
    chk("flush.valid", 32'(if0.out_valid), 0);
    chk("flush.in_ready", 32'(if0.in_ready), 1);

    drive(1, 32'h0000000b, 32'h400, 1, 0);
    chk("cust.ill", 32'(if0.out_illegal), 1);
    chk("cust.we", 32'(if0.out_rd_we), 0);
    drive(1, 32'h02208033, 32'h404, 1, 0);
    chk("mul0.ill", 32'(if0.out_illegal), 1);
    chk("mul1.ill", 32'(if1.out_illegal), 0);
    chk("mul1.alu", 32'(if1.out_op_alu), 32'(OP_MUL));
    chk("mul1.we", 32'(if1.out_rd_we), 0);

    pc = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, rnd_inst(), pc,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0);
      pc += 4;
    end

    drive(1, 32'h00100093, 32'h500, 0, 0);
    drive(1, 32'h00200113, 32'h504, 0, 0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.valid0", 32'(if0.out_valid), 0);
    chk("arst.valid1", 32'(if1.out_valid), 0);
    q0.delete();
    q1.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("arst.in_ready", 32'(if0.in_ready), 1);
    chk("arst.empty", 32'(if0.out_valid), 0);

    for (int n = 0; n < 150; n++) begin
      drive($urandom_range(0, 1) != 0, rnd_inst(), pc,
            $urandom_range(0, 9) < 6,
            $urandom_range(0, 29) == 0);
      pc += 4;
    end
    repeat (DEPTH + 2) drive(0, 0, 0, 1, 0);
    chk("drained", 32'(q0.size()), 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
